// File: rtl/seg7_scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_counter
// Brief    : Prescaled up/down hex counter driving a time-multiplexed
//            seven-segment display with optional leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_counter #(
    parameter int DIGITS         = 4,
    parameter int TICK_CYCLES    = 10000000,
    parameter int SCAN_CYCLES    = 1000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int LZ_BLANK       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  tick,
    output logic                  wrap
);

    localparam int c_COUNT_W = 4 * DIGITS;
    localparam int c_TICK_W  = $clog2(TICK_CYCLES);
    localparam int c_SCAN_W  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int c_IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_NSLOT   = 1 << c_IDX_W;
    localparam logic [DIGITS-1:0] c_DIG_ONE = DIGITS'(1);

    logic [c_TICK_W-1:0]  r_presc;
    logic [c_COUNT_W-1:0] r_count;
    logic                 r_tick;
    logic                 r_wrap;
    logic [c_SCAN_W-1:0]  r_scan;
    logic [c_IDX_W-1:0]   r_idx;
    logic [DIGITS-1:0]    r_dig_sel;
    logic [6:0]           r_seg;

    logic                 w_step;
    logic                 w_scan_last;
    logic [c_IDX_W-1:0]   w_idx_next;
    logic [3:0]           w_nib       [c_NSLOT];
    logic [c_NSLOT-1:0]   w_zero_from;
    logic [6:0]           w_hex;
    logic                 w_blank;

    assign w_step = en && (r_presc == c_TICK_W'(TICK_CYCLES - 1));

    // Counter path: load beats a step, and a step restarts the prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_count <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (load) begin
            r_presc <= '0;
            r_count <= load_val;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (w_step) begin
            r_presc <= '0;
            r_count <= up_dn ? (r_count + c_COUNT_W'(1)) : (r_count - c_COUNT_W'(1));
            r_tick  <= 1'b1;
            r_wrap  <= up_dn ? (&r_count) : (~|r_count);
        end else begin
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
            if (en) begin
                r_presc <= r_presc + c_TICK_W'(1);
            end
        end
    end

    assign w_scan_last = (r_scan == c_SCAN_W'(SCAN_CYCLES - 1));

    always_comb begin
        w_idx_next = r_idx;
        if (w_scan_last) begin
            w_idx_next = (r_idx == c_IDX_W'(DIGITS - 1)) ? '0 : (r_idx + c_IDX_W'(1));
        end
    end

    // Pad the nibble table to a power of two so any index value is legal.
    genvar k;
    generate
        for (k = 0; k < c_NSLOT; k++) begin : g_slot
            if (k < DIGITS) begin : g_real
                assign w_nib[k]       = r_count[4*k +: 4];
                assign w_zero_from[k] = ~|r_count[c_COUNT_W-1:4*k];
            end else begin : g_pad
                assign w_nib[k]       = 4'h0;
                assign w_zero_from[k] = 1'b1;
            end
        end
    endgenerate

    assign w_blank = (LZ_BLANK != 0) && (w_idx_next != '0) && w_zero_from[w_idx_next];

    always_comb begin
        w_hex = 7'h00;
        case (w_nib[w_idx_next])
            4'h0: w_hex = 7'h3F;
            4'h1: w_hex = 7'h06;
            4'h2: w_hex = 7'h5B;
            4'h3: w_hex = 7'h4F;
            4'h4: w_hex = 7'h66;
            4'h5: w_hex = 7'h6D;
            4'h6: w_hex = 7'h7D;
            4'h7: w_hex = 7'h07;
            4'h8: w_hex = 7'h7F;
            4'h9: w_hex = 7'h6F;
            4'hA: w_hex = 7'h77;
            4'hB: w_hex = 7'h7C;
            4'hC: w_hex = 7'h39;
            4'hD: w_hex = 7'h5E;
            4'hE: w_hex = 7'h79;
            4'hF: w_hex = 7'h71;
            default: w_hex = 7'h00;
        endcase
    end

    // Segment and select registers load together from the same next index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan    <= '0;
            r_idx     <= '0;
            r_dig_sel <= c_DIG_ONE;
            r_seg     <= 7'h3F;
        end else begin
            r_scan    <= w_scan_last ? '0 : (r_scan + c_SCAN_W'(1));
            r_idx     <= w_idx_next;
            r_dig_sel <= c_DIG_ONE << w_idx_next;
            r_seg     <= w_blank ? 7'h00 : w_hex;
        end
    end

    assign count   = r_count;
    assign tick    = r_tick;
    assign wrap    = r_wrap;
    assign seg     = (SEG_ACTIVE_LOW != 0) ? ~r_seg : r_seg;
    assign dig_sel = (SEG_ACTIVE_LOW != 0) ? ~r_dig_sel : r_dig_sel;

endmodule
`default_nettype wire
